// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-back path: register
// numbering constants and the write request record carried by the MDU,
// the write arbiter and the hazard unit.
package wb_write_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_REGS = 32;

  // One register-file write: destination, value and originating PC.
  typedef struct packed {
    logic [4:0]  dst_reg;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_req_t;

  // One-hot decode of a register number onto the pending mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] r);
    logic [NUM_REGS-1:0] oh;
    oh    = {NUM_REGS{1'b0}};
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the write-back sources (W stage, MDU) and the
// register-file write port. The arbiter sits on the slave side.
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int PTR_W = 2
);
  logic                pipe_we;
  logic [4:0]          pipe_reg;
  logic [31:0]         pipe_data;
  logic [31:0]         pipe_pc;
  logic                mdu_valid;
  logic                mdu_ready;
  logic [4:0]          mdu_reg;
  logic [31:0]         mdu_data;
  logic [31:0]         mdu_pc;
  logic                W_RegWrite;
  logic [4:0]          W_TargetReg;
  logic [31:0]         W_Data;
  logic [31:0]         WPC;
  logic [NUM_REGS-1:0] pending_mask;
  logic [PTR_W:0]      fifo_count;

  modport master (
    output pipe_we, pipe_reg, pipe_data, pipe_pc,
    output mdu_valid, mdu_reg, mdu_data, mdu_pc,
    input  mdu_ready,
    input  W_RegWrite, W_TargetReg, W_Data, WPC,
    input  pending_mask, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_reg, pipe_data, pipe_pc,
    input  mdu_valid, mdu_reg, mdu_data, mdu_pc,
    output mdu_ready,
    output W_RegWrite, W_TargetReg, W_Data, WPC,
    output pending_mask, fifo_count
  );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// In-order buffer of MDU write requests. Each slot carries a live bit so
// that entries overwritten by a younger pipeline write (WAW) can be killed
// in place and later popped without producing a register write.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [4:0]            squash_reg_i,
  output wb_req_t               head_o,
  output logic                  head_live_o,
  output logic [PTR_W:0]        count_o,
  output logic [DEPTH-1:0]      live_o,
  output logic [DEPTH-1:0][4:0] entry_reg_o
);

  wb_req_t              mem_q [DEPTH];
  logic [DEPTH-1:0]     live_q, live_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Occupancy alone tells full from empty, so guard both operations here.
  assign push_ok_s = push_i && (count_q < (PTR_W+1)'(DEPTH));
  assign pop_ok_s  = pop_i && (count_q != '0);

  // Next pointer/count values; a simultaneous push and pop keeps the count.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + (PTR_W+1)'(1);
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - (PTR_W+1)'(1);
      end
      2'b11: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Live bits: squash kills matching entries, pop retires the head, and a
  // push that collides with the squashing register enters already dead.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_i && live_q[i] && (mem_q[i].dst_reg == squash_reg_i)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_q[i];
      end
    end
    if (pop_ok_s) begin
      live_d[rd_ptr_q] = 1'b0;
    end else begin
      live_d[rd_ptr_q] = live_d[rd_ptr_q];
    end
    if (push_ok_s) begin
      live_d[wr_ptr_q] = !(squash_i && (push_req_i.dst_reg == squash_reg_i));
    end else begin
      live_d[wr_ptr_q] = live_d[wr_ptr_q];
    end
  end

  // Pointer, count and live-bit state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  // Entry storage; only the tail slot is written on an accepted push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_req_i;
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign head_live_o = live_q[rd_ptr_q] && (count_q != '0);
  assign count_o     = count_q;
  assign live_o      = live_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_reg
    assign entry_reg_o[g] = mem_q[g].dst_reg;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter. The W stage always owns the slot when it
// writes a real register; otherwise the oldest buffered MDU result drains.
// Also publishes which registers still have a buffered write outstanding.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                clk,
  input logic                reset,
  wb_write_arbiter_if.slave  bus
);

  wb_req_t              push_req_s;
  wb_req_t              head_s;
  logic                 head_live_s;
  logic [PTR_W:0]       count_s;
  logic [DEPTH-1:0]     live_s;
  logic [DEPTH-1:0][4:0] entry_reg_s;
  logic                 pipe_win_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 mdu_ready_s;
  logic [NUM_REGS-1:0]  mask_s;

  logic                 we_q, we_d;
  logic [4:0]           tgt_q, tgt_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          pc_q, pc_d;

  // Ready reflects current occupancy only; a same-cycle pop never helps.
  assign mdu_ready_s = (count_s < (PTR_W+1)'(DEPTH));
  assign pipe_win_s  = bus.pipe_we && (bus.pipe_reg != REG_ZERO);
  // Any idle slot retires the head, live or dead.
  assign pop_s       = !pipe_win_s && (count_s != '0);
  // Writes to $0 complete the handshake but are never stored.
  assign push_s      = bus.mdu_valid && mdu_ready_s && (bus.mdu_reg != REG_ZERO);

  assign push_req_s.dst_reg = bus.mdu_reg;
  assign push_req_s.data    = bus.mdu_data;
  assign push_req_s.pc      = bus.mdu_pc;

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_s),
    .push_req_i   (push_req_s),
    .pop_i        (pop_s),
    .squash_i     (pipe_win_s),
    .squash_reg_i (bus.pipe_reg),
    .head_o       (head_s),
    .head_live_o  (head_live_s),
    .count_o      (count_s),
    .live_o       (live_s),
    .entry_reg_o  (entry_reg_s)
  );

  // Slot selection: pipeline first, then a live FIFO head, else idle hold.
  always_comb begin
    we_d   = 1'b0;
    tgt_d  = tgt_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (pipe_win_s) begin
      we_d   = 1'b1;
      tgt_d  = bus.pipe_reg;
      data_d = bus.pipe_data;
      pc_d   = bus.pipe_pc;
    end else if (pop_s && head_live_s) begin
      we_d   = 1'b1;
      tgt_d  = head_s.dst_reg;
      data_d = head_s.data;
      pc_d   = head_s.pc;
    end else begin
      we_d   = 1'b0;
    end
  end

  // Registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q   <= 1'b0;
      tgt_q  <= 5'd0;
      data_q <= 32'd0;
      pc_q   <= 32'd0;
    end else begin
      we_q   <= we_d;
      tgt_q  <= tgt_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  // Pending mask: OR of one-hot destinations over live entries; $0 never set.
  always_comb begin
    mask_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (live_s[i]) begin
        mask_s = mask_s | reg_onehot(entry_reg_s[i]);
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0] = 1'b0;
  end

  assign bus.mdu_ready    = mdu_ready_s;
  assign bus.W_RegWrite   = we_q;
  assign bus.W_TargetReg  = tgt_q;
  assign bus.W_Data       = data_q;
  assign bus.WPC          = pc_q;
  assign bus.pending_mask = mask_s;
  assign bus.fifo_count   = count_s;

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the register-file write port (W_RegWrite / W_TargetReg / W_Data / WPC).
- Merges two write sources: pipeline W-stage results (highest priority, never stalled) and multi-cycle MDU results (valid/ready handshake, buffered in a small FIFO).
- Drains buffered MDU results into idle write slots.
- Exports a pending-register mask so the D-stage hazard logic can stall readers of not-yet-written registers.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low: state cleared on posedge clk when reset==0
- pipe_we  in  1  W-stage instruction writes a register
- pipe_reg  in  5  W-stage destination register
- pipe_data  in  32  W-stage write data
- pipe_pc  in  32  W-stage instruction PC
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept (combinational: not full)
- mdu_reg  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_pc  in  32  PC of the originating MDU instruction
- W_RegWrite  out  1  register-file write enable (registered)
- W_TargetReg  out  5  register-file write address (registered)
- W_Data  out  32  register-file write data (registered)
- WPC  out  32  PC for the write trace (registered)
- pending_mask  out  32  bit r=1 while a live FIFO entry targets register r; bit 0 always 0
- fifo_count  out  PTR_W+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge):
  - W_RegWrite, W_TargetReg, W_Data, WPC = 0.
  - FIFO emptied; pointers and count = 0.
  - pending_mask = 0.
  - Reset overrides any simultaneous push or drain; in-flight FIFO contents are discarded.
- Latency: a write selected in cycle N appears on the W_* outputs from posedge N+1 for exactly one cycle.
- Slot arbitration each cycle:
  - Pipeline wins if pipe_we==1 and pipe_reg!=0; outputs take the pipe_* values.
  - Otherwise, if the FIFO head is live, the head is popped and driven.
  - Otherwise W_RegWrite=0 and the other W_* outputs hold their previous values.
- Register $0: writes to reg 0 never assert W_RegWrite.
  - A pipe write to reg 0 counts as an idle slot.
  - An MDU push to reg 0 is accepted (handshake completes) but discarded, not enqueued.
- Handshake:
  - A push occurs when mdu_valid && mdu_ready at posedge.
  - mdu_ready = (fifo_count < DEPTH).
  - A pop in the same cycle does not raise ready early.
  - Push and pop in the same cycle leave the count unchanged.
  - An entry pushed in cycle N can be drained in cycle N+1 at earliest (no bypass from input to output).
- Ordering: FIFO is strictly in order; entries issue oldest first.
- Squash rule (WAW): MDU entries always originate from instructions older than the current W-stage instruction.
  - When the pipeline wins a slot writing register r, every live FIFO entry with reg==r is marked dead in that cycle.
  - Dead entries are popped without asserting W_RegWrite, consuming that idle slot.
  - Dead entries clear their pending_mask bit immediately.
- pending_mask: OR of one-hot(reg) over live entries.
  - Updated at the same posedge as push, pop, and squash.
  - An entry leaving the FIFO clears its bit in the same edge that W_RegWrite rises.
- Wrap-around: pointers are modulo DEPTH; full/empty are distinguished by fifo_count.
- Starvation: MDU entries may wait indefinitely under continuous pipeline writes.
  - Back-pressure is conveyed only through mdu_ready; the hazard unit is responsible for forward progress.

Decomposition:
- Shared package holds:
  - REG_ZERO = 5'd0, NUM_REGS = 32
  - wb_req_t struct {reg[4:0], data[31:0], pc[31:0]}, reused by the MDU and hazard unit
- One natural sub-module: wb_fifo.
  - Parameterized DEPTH storage of wb_req_t plus live bits.
  - push/pop/squash-by-reg ports; exposes count and the live-entry vector.
- The arbiter mux, output registers and pending_mask reduction stay in the top.

Test Plan:
- Reset: drive reset=0 with FIFO holding 3 entries → next edge: fifo_count=0, pending_mask=0, W_RegWrite=0, mdu_ready=1.
- Idle drain: push mdu_reg=8, mdu_data=0x1234, mdu_pc=0x3000 with pipe_we=0.
  - Next cycle W_RegWrite=1, W_TargetReg=8, W_Data=0x1234, WPC=0x3000.
  - pending_mask[8] is set for one cycle, then clears.
- Priority/full: hold pipe_we=1, pipe_reg=5 for 6 cycles while pushing regs 9,10,11,12,13.
  - Only 4 pushes accepted; mdu_ready=0 at count 4.
  - After pipe_we drops, outputs are 9,10,11,12 in order on consecutive cycles.
- Squash: FIFO holds reg 7 (data 0xAA); pipe writes reg 7 data 0xBB.
  - W_Data=0xBB; entry dropped; pending_mask[7]=0.
  - No later write of 0xAA occurs.
- $0 handling:
  - pipe_we=1, pipe_reg=0 with a FIFO head for reg 4 → reg 4 drains that cycle.
  - MDU push to reg 0 → accepted, fifo_count unchanged, no write.
- Simultaneous push+pop at count=4 (full): mdu_ready=0, so push is refused; pop brings count to 3; ready rises the next cycle.
